// File: rtl/sram_word_controller_if.sv
// CPU-side request/response bus between the MEM stage and the SRAM word controller.
//   rd_en  : load request, level, held until ready
//   wr_en  : store request, level, held until ready
//   addr   : CPU byte address, word aligned
//   wdata  : store data
//   rdata  : load data (registered in the controller)
//   ready  : 1 = no access pending, or current access completing this cycle
// The MEM stage is the master; the controller is the slave.
interface sram_word_controller_if #(
  parameter int DATA_LEN = 32
);
  logic                rd_en;
  logic                wr_en;
  logic [DATA_LEN-1:0] addr;
  logic [DATA_LEN-1:0] wdata;
  logic [DATA_LEN-1:0] rdata;
  logic                ready;

  modport master (
    output rd_en, wr_en, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  rd_en, wr_en, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/sram_word_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM accesses
// (low half first, then high half), each held for WAIT_CYCLES clocks.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   bus        : CPU-side request bus (slave modport)
//   SRAM_DQ    : SRAM data, driven only while writing, else high-Z
//   SRAM_ADDR  : SRAM half-word address, registered
//   SRAM_UB_N, SRAM_LB_N, SRAM_CE_N : tied low
//   SRAM_WE_N  : low only while writing, registered
//   SRAM_OE_N  : low only while reading, registered
module sram_word_controller #(
  parameter int DATA_LEN      = 32,
  parameter int SRAM_DATA_LEN = 16,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int WAIT_CYCLES   = 3,
  parameter int BASE_ADDR     = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_word_controller_if.slave    bus,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [CNT_W-1:0]           r_cnt;
  logic                       w_last;
  logic                       w_in_phase;
  logic                       w_enter_hi;
  logic [DATA_LEN-1:0]        w_off;
  logic [SRAM_ADDR_LEN-2:0]   w_word_in;
  logic                       w_unused;
  logic [SRAM_ADDR_LEN-2:0]   r_word;
  logic [SRAM_DATA_LEN-1:0]   r_wdata_hi;
  logic [SRAM_DATA_LEN-1:0]   r_dq_out;
  logic                       r_dq_en;
  logic [DATA_LEN-1:0]        r_rdata;
  logic [SRAM_ADDR_LEN-1:0]   r_sram_addr;
  logic                       r_we_n;
  logic                       r_oe_n;

  // Word index inside the SRAM; bits above SRAM_ADDR_LEN alias away by truncation.
  assign w_off     = bus.addr - DATA_LEN'(BASE_ADDR);
  assign w_word_in = w_off[SRAM_ADDR_LEN:2];
  assign w_unused  = ^{w_off[DATA_LEN-1:SRAM_ADDR_LEN+1], w_off[1:0]};

  assign w_in_phase = (r_state == RD_LO) || (r_state == RD_HI) ||
                      (r_state == WR_LO) || (r_state == WR_HI);
  assign w_last     = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign w_enter_hi = w_last && ((r_state == RD_LO) || (r_state == WR_LO));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        // Store wins when both requests are up.
        if (bus.wr_en)      w_next = WR_LO;
        else if (bus.rd_en) w_next = RD_LO;
      end
      RD_LO:   if (w_last) w_next = RD_HI;
      RD_HI:   if (w_last) w_next = DONE;
      WR_LO:   if (w_last) w_next = WR_HI;
      WR_HI:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_dq_en     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_in_phase)   r_cnt <= r_cnt + 1'b1;

      // Address is set up on the edge entering each half so it is stable for the whole phase.
      if (r_state == IDLE && w_next != IDLE) r_sram_addr <= {w_word_in, 1'b0};
      else if (w_enter_hi)                   r_sram_addr <= {r_word, 1'b1};

      r_we_n  <= !((w_next == WR_LO) || (w_next == WR_HI));
      r_oe_n  <= !((w_next == RD_LO) || (w_next == RD_HI));
      r_dq_en <=  (w_next == WR_LO) || (w_next == WR_HI);

      // Capture read data at the end of each phase, after the SRAM has had the full wait.
      if (r_state == RD_LO && w_last) r_rdata[SRAM_DATA_LEN-1:0]        <= SRAM_DQ;
      if (r_state == RD_HI && w_last) r_rdata[DATA_LEN-1:SRAM_DATA_LEN] <= SRAM_DQ;
    end
  end

  // Request operands are frozen while leaving IDLE; later changes are ignored.
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      r_word     <= w_word_in;
      r_wdata_hi <= bus.wdata[DATA_LEN-1:SRAM_DATA_LEN];
      r_dq_out   <= bus.wdata[SRAM_DATA_LEN-1:0];
    end else if (w_enter_hi) begin
      r_dq_out   <= r_wdata_hi;
    end
  end

  assign bus.ready = (!bus.rd_en && !bus.wr_en) || (r_state == DONE);
  assign bus.rdata = r_rdata;

  assign SRAM_DQ   = r_dq_en ? r_dq_out : {SRAM_DATA_LEN{1'bz}};
  assign SRAM_ADDR = r_sram_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_OE_N = r_oe_n;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;

endmodule

// File: tb/tb_sram_word_controller.sv
module tb_sram_word_controller;

  localparam int WAIT = 3;
  localparam int BASE = 1024;
  localparam int LAT  = 2 * WAIT + 2;
  localparam int NH   = 262144;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_word_controller_if #(.DATA_LEN(32)) bus();

  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N;

  sram_word_controller #(
    .DATA_LEN(32), .SRAM_DATA_LEN(16), .SRAM_ADDR_LEN(18),
    .WAIT_CYCLES(WAIT), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  // External SRAM model and the expected memory contents.
  logic [15:0] mem     [0:NH-1];
  logic [15:0] ref_mem [0:NH-1];

  assign SRAM_DQ = (!SRAM_OE_N) ? mem[SRAM_ADDR] : 16'hzzzz;
  always @(posedge clk) if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Index of the low half-word a CPU byte address lands on.
  function automatic int unsigned half_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return ((off >> 2) % (NH / 2)) * 2;
  endfunction

  // Reference effect of one access on expected memory; returns the load result.
  function automatic logic [31:0] model_access(input bit rd, input bit wr,
                                               input logic [31:0] a, input logic [31:0] d,
                                               input logic [31:0] prev);
    int unsigned h;
    h = half_idx(a);
    if (wr) begin
      ref_mem[h]     = d[15:0];
      ref_mem[h + 1] = d[31:16];
      return prev;
    end
    if (rd) return {ref_mem[h + 1], ref_mem[h]};
    return prev;
  endfunction

  // Called just after a negedge. Presents the request and counts cycles until ready.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d, input bit hold,
                            output int cyc, output int we_lo, output int oe_lo);
    bus.rd_en = rd; bus.wr_en = wr; bus.addr = a; bus.wdata = d;
    cyc = 0; we_lo = 0; oe_lo = 0;
    for (int k = 0; k < 64; k++) begin
      #1;
      cyc++;
      if (!SRAM_WE_N) we_lo++;
      if (!SRAM_OE_N) oe_lo++;
      if (bus.ready) break;
      @(negedge clk);
    end
    if (!hold) begin
      bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    end
  endtask

  logic [31:0] last_rdata;
  logic [31:0] exp;
  int          cyc, we_lo, oe_lo;
  int unsigned h;

  initial begin
    rst = 1'b0;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < NH; i++) begin
      mem[i] = 16'h0; ref_mem[i] = 16'h0;
    end
    for (int i = 0; i < 128; i++) begin
      mem[i] = 16'($urandom); ref_mem[i] = mem[i];
    end
    mem[0] = 16'h5678; mem[1] = 16'h1234; mem[NH-2] = 16'hAAAA; mem[NH-1] = 16'h5555;
    ref_mem[0] = 16'h5678; ref_mem[1] = 16'h1234; ref_mem[NH-2] = 16'hAAAA; ref_mem[NH-1] = 16'h5555;

    vt[0]  = '{1'b1, 1'b0, 32'd1024,            32'h0,        32'h12345678};
    vt[1]  = '{1'b0, 1'b1, 32'd1028,            32'hDEADBEEF, 32'h12345678};
    vt[2]  = '{1'b1, 1'b1, 32'd1032,            32'hCAFEF00D, 32'h12345678};
    vt[3]  = '{1'b1, 1'b0, 32'd1032,            32'h0,        32'hCAFEF00D};
    vt[4]  = '{1'b1, 1'b0, 32'd1028,            32'h0,        32'hDEADBEEF};
    vt[5]  = '{1'b1, 1'b0, 32'd1024,            32'h0,        32'h12345678};
    vt[6]  = '{1'b0, 1'b1, 32'd1024,            32'h0000FFFF, 32'h12345678};
    vt[7]  = '{1'b1, 1'b0, 32'd1024,            32'h0,        32'h0000FFFF};
    vt[8]  = '{1'b1, 1'b0, 32'd1028 + 32'h80000, 32'h0,       32'hDEADBEEF};
    vt[9]  = '{1'b1, 1'b0, 32'd1020,            32'h0,        32'h5555AAAA};
    vt[10] = '{1'b0, 1'b1, 32'd1020,            32'h13579BDF, 32'h5555AAAA};
    vt[11] = '{1'b1, 1'b0, 32'd1020,            32'h0,        32'h13579BDF};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_strobes", {bus.ready, SRAM_WE_N, SRAM_OE_N}, 3'b111);
    chk("reset_addr", SRAM_ADDR, 18'h0);
    chk("const_pins", {SRAM_UB_N, SRAM_LB_N, SRAM_CE_N}, 3'b000);
    @(negedge clk);
    rst = 1'b1;

    // Idle with no request
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      chk("idle", {bus.ready, SRAM_WE_N, SRAM_OE_N, SRAM_ADDR}, {3'b111, 18'h0});
    end

    // Directed vector table
    last_rdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      run_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, 1'b0, cyc, we_lo, oe_lo);
      last_rdata = model_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, last_rdata);
      chk($sformatf("vec%0d_latency", i), cyc, LAT);
      chk($sformatf("vec%0d_we_low", i), we_lo, vt[i].wr ? 2 * WAIT : 0);
      chk($sformatf("vec%0d_oe_low", i), oe_lo, vt[i].wr ? 0 : 2 * WAIT);
      chk($sformatf("vec%0d_rdata", i), bus.rdata, vt[i].exp_rdata);
      if (vt[i].wr) begin
        h = half_idx(vt[i].addr);
        chk($sformatf("vec%0d_sram", i), {mem[h + 1], mem[h]}, {ref_mem[h + 1], ref_mem[h]});
      end
      @(negedge clk); #1;
      chk($sformatf("vec%0d_after", i), {bus.ready, SRAM_WE_N, SRAM_OE_N}, 3'b111);
    end
    chk("mem2_3", {mem[3], mem[2]}, 32'hDEADBEEF);
    chk("mem4_5", {mem[5], mem[4]}, 32'hCAFEF00D);

    // Request held through DONE starts a second access immediately
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, cyc, we_lo, oe_lo);
    chk("held_first_latency", cyc, LAT);
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, cyc, we_lo, oe_lo);
    chk("held_second_latency", cyc, LAT);
    chk("held_rdata", bus.rdata, 32'hCAFEF00D);

    // Reset while in the high read phase
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = 32'd1028;
    repeat (4) @(negedge clk);
    #1;
    chk("midread_oe", SRAM_OE_N, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_rdata", bus.rdata, 32'h0);
    chk("midrst_strobes", {SRAM_WE_N, SRAM_OE_N, SRAM_ADDR}, {2'b11, 18'h0});
    bus.rd_en = 1'b0;
    #1;
    chk("midrst_ready", bus.ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, cyc, we_lo, oe_lo);
    chk("post_rst_latency", cyc, LAT);
    chk("post_rst_rdata", bus.rdata, {ref_mem[1], ref_mem[0]});
    last_rdata = {ref_mem[1], ref_mem[0]};

    // Randomized accesses against the reference model
    for (int i = 0; i < 60; i++) begin
      logic        rd, wr;
      logic [31:0] a, d;
      rd = 1'($urandom); wr = 1'($urandom);
      a  = 32'(BASE) + 32'(4 * $urandom_range(0, 31));
      d  = $urandom;
      @(negedge clk);
      if (!rd && !wr) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        #1;
        chk("rand_idle", {bus.ready, bus.rdata}, {1'b1, last_rdata});
      end else begin
        run_access(rd, wr, a, d, 1'b0, cyc, we_lo, oe_lo);
        exp = model_access(rd, wr, a, d, last_rdata);
        last_rdata = exp;
        chk("rand_latency", cyc, LAT);
        chk("rand_rdata", bus.rdata, exp);
        if (wr) begin
          h = half_idx(a);
          chk("rand_sram", {mem[h + 1], mem[h]}, {ref_mem[h + 1], ref_mem[h]});
        end
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
